// File: rtl/dps_pkg.sv
// dps_pkg: shared widths, buffer entry layout and unpacker states for the pixel readout path.
package dps_pkg;
  localparam int WORD_W = 32;
  localparam int PIX_W = 8;
  localparam int LANES = 4;
  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              sof;
    logic              eof;
  } rob_entry_t;
  typedef enum logic {IDLE, EMIT} rob_state_t;
endpackage

// File: rtl/readout_fifo.sv
// readout_fifo: synchronous FIFO of tagged sensor words with wrap-bit pointers.
module readout_fifo
  import dps_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  rob_entry_t din,
  output rob_entry_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  rob_entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign do_push = push && (!full || do_pop);
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/pixel_readout_buffer.sv
// pixel_readout_buffer: buffers sensor bus words and unpacks them into a framed pixel stream.
module pixel_readout_buffer
  import dps_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int PIX_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WORDS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] bus_data,
  input  logic              bus_valid,
  input  logic              frame_start,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic              overflow,
  output logic [15:0]       frame_count
);
  localparam int CW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CW-1:0] LAST_W = CW'(FRAME_WORDS - 1);
  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_L = LW'(LANES - 1);
  rob_state_t state, state_n;
  rob_entry_t sr, fifo_in, fifo_out;
  logic [CW-1:0] wcnt, wcur;
  logic [LW-1:0] lane;
  logic full, empty, pop, hs, last;
  assign wcur = frame_start ? '0 : wcnt;
  assign fifo_in = {bus_data, wcur == '0, wcur == LAST_W};
  assign hs = pix_valid && pix_ready;
  assign last = hs && lane == LAST_L;
  assign pix_valid = state == EMIT;
  assign pix_data = pix_valid ? sr.word[lane*PIX_W +: PIX_W] : '0;
  assign pix_sof = pix_valid && sr.sof && lane == '0;
  assign pix_eof = pix_valid && sr.eof && lane == LAST_L;
  readout_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus_valid),
    .pop   (pop),
    .din   (fifo_in),
    .dout  (fifo_out),
    .full  (full),
    .empty (empty)
  );
  // refill straight from the FIFO on the last lane so words stream without a bubble
  always_comb begin
    pop = !empty && (state == IDLE || last);
    state_n = pop ? EMIT : last ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      lane <= '0;
      wcnt <= '0;
      overflow <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_n;
      if (pop) begin
        sr <= fifo_out;
        lane <= '0;
      end else if (hs) lane <= lane + 1'b1;
      if (bus_valid || frame_start) wcnt <= !bus_valid ? '0 : wcur == LAST_W ? '0 : wcur + 1'b1;
      if (bus_valid && full && !pop) overflow <= 1'b1;
      if (hs && pix_eof) frame_count <= frame_count + 1'b1;
    end
endmodule
